// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
//   Types and constants shared by the systolic array blocks.
//   DATA_W / FRAC_W : element width and fraction bits of the signed Q8.8 format
//   fixed_t         : one array element
//   feeder_state_t  : state encoding of systolic_feeder
// ---------------------------------------------------------------------------
package tpu_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    typedef logic signed [15:0] fixed_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_SWITCH = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_feeder_if
//   Host-side weight and input channels of systolic_feeder.
//   w_valid/w_ready/w_data : one weight row per beat, element j in w_data[j]
//   x_valid/x_ready/x_data : one input vector per beat, element i -> row i
//   x_last                 : final vector of a stream
//   master : host buffers      slave : feeder
// ---------------------------------------------------------------------------
interface systolic_feeder_if #(
    parameter int N      = 2,
    parameter int DATA_W = 16
);
    logic                       w_valid;
    logic                       w_ready;
    logic [N-1:0][DATA_W-1:0]   w_data;
    logic                       x_valid;
    logic                       x_ready;
    logic [N-1:0][DATA_W-1:0]   x_data;
    logic                       x_last;

    modport master (
        output w_valid, w_data, x_valid, x_data, x_last,
        input  w_ready, x_ready
    );

    modport slave (
        input  w_valid, w_data, x_valid, x_data, x_last,
        output w_ready, x_ready
    );
endinterface

// File: rtl/skew_delay.sv
// ---------------------------------------------------------------------------
// skew_delay
//   Data + valid shift register of DEPTH stages. DEPTH=0 is a plain wire.
//   clk, rst       : clock, asynchronous active-low clear
//   i_data, i_vld  : stage input
//   o_data, o_vld  : output DEPTH cycles later
// ---------------------------------------------------------------------------
module skew_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_vld,
    output logic [W-1:0] o_data,
    output logic         o_vld
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk;
            assign w_unused_clk = clk ^ rst;
            assign o_data       = i_data;
            assign o_vld        = i_vld;
        end else begin : g_pipe
            logic [DEPTH-1:0][W-1:0] r_dat_pipe;
            logic [DEPTH-1:0]        r_vld_pipe;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dat_pipe <= '0;
                    r_vld_pipe <= '0;
                end else begin
                    r_dat_pipe[0] <= i_data;
                    r_vld_pipe[0] <= i_vld;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_dat_pipe[k] <= r_dat_pipe[k-1];
                        r_vld_pipe[k] <= r_vld_pipe[k-1];
                    end
                end
            end

            assign o_data = r_dat_pipe[DEPTH-1];
            assign o_vld  = r_vld_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//   Feeds the north (weights, accept_w, switch) and west (inputs, valid)
//   edges of an N x N systolic array.
//   clk, rst          : clock, asynchronous active-low reset
//   host              : weight/input channels (slave side)
//   pe_weight_out     : weight row per column, with pe_accept_w_out
//   pe_switch_out     : per-column switch pulse, staggered by column index
//   pe_input_out      : skewed input per row, with pe_valid_out
//   pe_enabled_out    : array enable, SWITCH through last DRAIN cycle
//   busy              : FSM not in IDLE
//   done              : one-cycle pulse on the last DRAIN cycle
// ---------------------------------------------------------------------------
module systolic_feeder #(
    parameter int N      = 2,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    systolic_feeder_if.slave         host,
    output logic [N-1:0][DATA_W-1:0] pe_weight_out,
    output logic [N-1:0]             pe_accept_w_out,
    output logic [N-1:0]             pe_switch_out,
    output logic [N-1:0][DATA_W-1:0] pe_input_out,
    output logic [N-1:0]             pe_valid_out,
    output logic                     pe_enabled_out,
    output logic                     busy,
    output logic                     done
);
    import tpu_pkg::*;

    localparam int            CW         = $clog2(N);
    localparam logic [CW-1:0] LAST_BEAT  = CW'(N - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(N - 2);

    feeder_state_t            r_state;
    logic [CW-1:0]            r_cnt;
    logic                     r_w_ready;
    logic                     r_x_ready;
    logic                     r_busy;
    logic                     r_enabled;
    logic                     r_done;
    logic                     r_sw;
    logic [N-1:0][DATA_W-1:0] r_weight;
    logic [N-1:0]             r_accept_w;
    logic [N-1:0][DATA_W-1:0] r_x_data;
    logic                     r_x_vld;

    logic                     w_w_acc;
    logic                     w_x_acc;
    logic [N-1:0]             w_sw_dat;
    logic [N-1:0]             w_sw_vld;

    assign w_w_acc = host.w_valid && r_w_ready;
    assign w_x_acc = host.x_valid && r_x_ready;

    // Control FSM; every control output is a register so all of them are
    // 0 while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_w_ready <= 1'b0;
            r_x_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_enabled <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_w_ready <= 1'b1;
                    r_x_ready <= 1'b0;
                    r_enabled <= 1'b0;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                    if (w_w_acc) begin
                        r_state <= ST_LOAD_W;
                        r_cnt   <= CW'(1);
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD_W: begin
                    if (w_w_acc) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_state   <= ST_SWITCH;
                            r_cnt     <= '0;
                            r_w_ready <= 1'b0;
                            r_enabled <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_SWITCH: begin
                    r_state   <= ST_STREAM;
                    r_x_ready <= 1'b1;
                end
                ST_STREAM: begin
                    if (w_x_acc && host.x_last) begin
                        r_state   <= ST_DRAIN;
                        r_cnt     <= '0;
                        r_x_ready <= 1'b0;
                        // A single-cycle drain is also its last cycle.
                        r_done    <= (LAST_DRAIN == '0);
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == LAST_DRAIN) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_done    <= 1'b0;
                        r_enabled <= 1'b0;
                        r_busy    <= 1'b0;
                        r_w_ready <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_done <= (r_cnt == LAST_DRAIN - 1'b1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_w_ready <= 1'b0;
                    r_x_ready <= 1'b0;
                    r_busy    <= 1'b0;
                    r_enabled <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    // Edge registers: weight row (all columns in parallel), input vector
    // ahead of the skew lines, and the switch trigger. Empty slots carry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_weight   <= '0;
            r_accept_w <= '0;
            r_x_data   <= '0;
            r_x_vld    <= 1'b0;
            r_sw       <= 1'b0;
        end else begin
            r_weight   <= w_w_acc ? host.w_data : '0;
            r_accept_w <= {N{w_w_acc}};
            r_x_data   <= w_x_acc ? host.x_data : '0;
            r_x_vld    <= w_x_acc;
            // High in the cycle after SWITCH; column j sees it j cycles later.
            r_sw       <= (r_state == ST_SWITCH);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            skew_delay #(.DEPTH(gi), .W(DATA_W)) u_row_skew (
                .clk    (clk),
                .rst    (rst),
                .i_data (r_x_data[gi]),
                .i_vld  (r_x_vld),
                .o_data (pe_input_out[gi]),
                .o_vld  (pe_valid_out[gi])
            );

            // Both bits carry the same pulse; the switch is their AND.
            skew_delay #(.DEPTH(gi), .W(1)) u_sw_skew (
                .clk    (clk),
                .rst    (rst),
                .i_data (r_sw),
                .i_vld  (r_sw),
                .o_data (w_sw_dat[gi]),
                .o_vld  (w_sw_vld[gi])
            );
            assign pe_switch_out[gi] = w_sw_dat[gi] & w_sw_vld[gi];
        end
    endgenerate

    assign host.w_ready    = r_w_ready;
    assign host.x_ready    = r_x_ready;
    assign pe_weight_out   = r_weight;
    assign pe_accept_w_out = r_accept_w;
    assign pe_enabled_out  = r_enabled;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
//   Directed bench for systolic_feeder at N=2 with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_systolic_feeder;
    localparam int N  = 2;
    localparam int DW = 16;

    localparam logic [31:0] WA = {16'h0A9A, 16'h0459};
    localparam logic [31:0] WB = {16'hFC9A, 16'h05C0};
    localparam logic [31:0] XA = {16'h00A1, 16'h00A0};
    localparam logic [31:0] XB = {16'h00B1, 16'h00B0};
    localparam logic [31:0] XC = {16'h0C01, 16'h0C00};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .DATA_W(DW)) host ();

    logic [N-1:0][DW-1:0] pe_weight_out;
    logic [N-1:0]         pe_accept_w_out;
    logic [N-1:0]         pe_switch_out;
    logic [N-1:0][DW-1:0] pe_input_out;
    logic [N-1:0]         pe_valid_out;
    logic                 pe_enabled_out;
    logic                 busy;
    logic                 done;

    systolic_feeder #(.N(N), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .host            (host),
        .pe_weight_out   (pe_weight_out),
        .pe_accept_w_out (pe_accept_w_out),
        .pe_switch_out   (pe_switch_out),
        .pe_input_out    (pe_input_out),
        .pe_valid_out    (pe_valid_out),
        .pe_enabled_out  (pe_enabled_out),
        .busy            (busy),
        .done            (done)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        host.w_valid = 1'b0;
        host.w_data  = '0;
        host.x_valid = 1'b0;
        host.x_data  = '0;
        host.x_last  = 1'b0;

        // reset state
        #12;
        chk("rst_acc",   pe_accept_w_out, 0);
        chk("rst_vld",   pe_valid_out,    0);
        chk("rst_sw",    pe_switch_out,   0);
        chk("rst_busy",  busy,            0);
        chk("rst_wrdy",  host.w_ready,    0);
        chk("rst_en",    pe_enabled_out,  0);
        rst = 1'b1;
        step;
        step;
        chk("idle_wrdy", host.w_ready, 1);
        chk("idle_xrdy", host.x_ready, 0);
        chk("idle_busy", busy,         0);

        // weight load, no gaps
        host.w_valid = 1'b1; host.w_data = WA;
        step;
        chk("ld1_acc",  pe_accept_w_out, 2'b11);
        chk("ld1_w",    pe_weight_out,   WA);
        chk("ld1_busy", busy,            1);
        host.w_data = WB;
        step;
        chk("ld2_acc",  pe_accept_w_out, 2'b11);
        chk("ld2_w",    pe_weight_out,   WB);
        chk("sw_wrdy",  host.w_ready,    0);
        chk("sw_en",    pe_enabled_out,  1);
        chk("sw_none",  pe_switch_out,   2'b00);
        host.w_valid = 1'b0; host.w_data = '0;
        step;
        chk("ld3_acc",  pe_accept_w_out, 2'b00);
        chk("ld3_w",    pe_weight_out,   0);
        chk("sw_col0",  pe_switch_out,   2'b01);
        chk("st_xrdy",  host.x_ready,    1);
        step;
        chk("sw_col1",  pe_switch_out,   2'b10);
        chk("st_novld", pe_valid_out,    0);

        // skew, single-vector stream
        host.x_valid = 1'b1; host.x_data = {16'hFC9A, 16'h0200}; host.x_last = 1'b1;
        step;
        chk("sk1_vld",  pe_valid_out,  2'b01);
        chk("sk1_in",   pe_input_out,  32'h0000_0200);
        chk("sk1_done", done,          1);
        chk("sk1_xrdy", host.x_ready,  0);
        host.x_valid = 1'b0; host.x_data = '0; host.x_last = 1'b0;
        step;
        chk("sk2_vld",  pe_valid_out,  2'b10);
        chk("sk2_in",   pe_input_out,  32'hFC9A_0000);
        chk("sk2_done", done,          0);
        chk("sk2_busy", busy,          0);
        chk("sk2_en",   pe_enabled_out, 0);
        step;
        chk("sk3_vld",  pe_valid_out,  0);

        // back-pressure on x during load, then bubble with w back-pressure
        host.x_valid = 1'b1; host.x_data = 32'h1111_2222;
        host.w_valid = 1'b1; host.w_data = WB;
        step;
        chk("bp1_xrdy", host.x_ready,    0);
        chk("bp1_vld",  pe_valid_out,    0);
        chk("bp1_acc",  pe_accept_w_out, 2'b11);
        host.w_data = WA;
        step;
        chk("bp2_xrdy", host.x_ready,    0);
        chk("bp2_w",    pe_weight_out,   WA);
        host.w_valid = 1'b0;
        step;
        chk("bp3_vld",  pe_valid_out,    0);
        chk("bp3_xrdy", host.x_ready,    1);
        host.x_data = XA; host.w_valid = 1'b1;
        step;
        chk("bu1_vld",  pe_valid_out,    2'b01);
        chk("bu1_in",   pe_input_out,    {16'h0000, 16'h00A0});
        chk("bu1_acc",  pe_accept_w_out, 2'b00);
        chk("bu1_wrdy", host.w_ready,    0);
        host.x_valid = 1'b0;
        step;
        chk("bu2_vld",  pe_valid_out,    2'b10);
        chk("bu2_in",   pe_input_out,    {16'h00A1, 16'h0000});
        chk("bu2_acc",  pe_accept_w_out, 2'b00);
        host.x_valid = 1'b1; host.x_data = XB; host.x_last = 1'b1;
        step;
        chk("bu3_vld",  pe_valid_out,    2'b01);
        chk("bu3_in",   pe_input_out,    {16'h0000, 16'h00B0});
        chk("bu3_done", done,            1);
        host.x_valid = 1'b0; host.x_data = '0; host.x_last = 1'b0; host.w_valid = 1'b0;
        step;
        chk("bu4_vld",  pe_valid_out,    2'b10);
        chk("bu4_in",   pe_input_out,    {16'h00B1, 16'h0000});
        chk("bu4_busy", busy,            0);

        // weight gap
        host.w_valid = 1'b1; host.w_data = WA;
        step;
        chk("wg1_acc",  pe_accept_w_out, 2'b11);
        host.w_valid = 1'b0;
        step;
        chk("wg2_acc",  pe_accept_w_out, 2'b00);
        chk("wg2_wrdy", host.w_ready,    1);
        chk("wg2_en",   pe_enabled_out,  0);
        step;
        chk("wg3_acc",  pe_accept_w_out, 2'b00);
        chk("wg3_en",   pe_enabled_out,  0);
        chk("wg3_sw",   pe_switch_out,   2'b00);
        host.w_valid = 1'b1; host.w_data = WB;
        step;
        chk("wg4_acc",  pe_accept_w_out, 2'b11);
        chk("wg4_w",    pe_weight_out,   WB);
        chk("wg4_en",   pe_enabled_out,  1);
        host.w_valid = 1'b0;
        step;
        chk("wg5_sw",   pe_switch_out,   2'b01);
        step;
        chk("wg6_sw",   pe_switch_out,   2'b10);

        // reset mid-stream with row 1 still pending
        host.x_valid = 1'b1; host.x_data = XC;
        step;
        chk("rm1_vld",  pe_valid_out,    2'b01);
        host.x_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rm_vld",   pe_valid_out,    0);
        chk("rm_in",    pe_input_out,    0);
        chk("rm_busy",  busy,            0);
        chk("rm_en",    pe_enabled_out,  0);
        chk("rm_xrdy",  host.x_ready,    0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step;
            chk("rp_vld",  pe_valid_out,  0);
            chk("rp_sw",   pe_switch_out, 0);
            chk("rp_busy", busy,          0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
